// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers LENGTH-bit words in a DEPTH-entry FIFO and shifts them out one bit per clock.
// Latency: 2 edges from word acceptance (into an empty FIFO, idle shifter) to the first valid bit.
// Backpressure: s_ready drops only while DEPTH words wait behind the shifter; a same-cycle pop does not free a slot.
module bit_serializer #(
    parameter int LENGTH    = 4,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [LENGTH-1:0]          s_data,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(LENGTH);
    localparam int NW = $clog2(DEPTH+1);

    localparam logic [CW-1:0] LAST_BIT = CW'(LENGTH - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [LENGTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [0:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [LENGTH-1:0] shreg;
    logic [CW-1:0]     bit_idx;
    logic              push;
    logic              pop;
    logic              last_bit;

    // Ready looks only at the registered count, so a full FIFO refuses a word even when the shifter pops that cycle.
    assign s_ready  = !rst && (fifo_count != FULL_CNT);
    assign push     = s_valid && s_ready;
    assign last_bit = (bit_cnt == LAST_BIT);
    // Load the shifter when idle, or back-to-back on the last bit so consecutive words leave no gap.
    assign pop      = (fifo_count != '0) && ((state == IDLE) || ((state == SHIFT) && last_bit));

    // Storage array: written on push, no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count moves only on an unbalanced push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Shifter FSM: a reset drops any partial word outright; it is never replayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (pop) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= mem[rd_ptr];
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Bit select from registered shifter and counter only; nothing from s_data reaches bit_out.
    always_comb begin
        bit_idx = bit_cnt;
        if (MSB_FIRST != 0) begin
            bit_idx = LAST_BIT - bit_cnt;
        end
    end

    assign busy      = (state == SHIFT);
    assign bit_valid = (state == SHIFT);
    assign bit_out   = (state == SHIFT) && shreg[bit_idx];

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first and LSB-first instances share one input stream.
// A scoreboard queues expected bits at each accepted word and compares every valid bit emitted.
// Table-driven single-word latency checks plus hand sequences for back-to-back, fill, full+pop and mid-word reset.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [3:0] s_data;
    logic       s_ready, s_ready_l;
    logic       bit_out, bit_out_l;
    logic       bit_valid, bit_valid_l;
    logic       busy, busy_l;
    logic [2:0] fifo_count, fifo_count_l;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    logic q_m[$];
    logic q_l[$];

    bit_serializer #(.LENGTH(4), .DEPTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .fifo_count(fifo_count)
    );

    bit_serializer #(.LENGTH(4), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_l), .s_data(s_data),
        .bit_out(bit_out_l), .bit_valid(bit_valid_l), .busy(busy_l), .fifo_count(fifo_count_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare emitted bits, flush on reset, queue expected bits for words about to be accepted.
    always @(negedge clk) begin
        logic e;
        if (mon_en) begin
            check("busy_mirror_msb", busy, bit_valid);
            check("busy_mirror_lsb", busy_l, bit_valid_l);
            check("s_ready_match", s_ready_l, s_ready);
            if (bit_valid) begin
                if (q_m.size() == 0) begin
                    check("msb_spurious_bit", bit_valid, 1'b0);
                end else begin
                    e = q_m.pop_front();
                    check("msb_bit", bit_out, e);
                end
            end
            if (bit_valid_l) begin
                if (q_l.size() == 0) begin
                    check("lsb_spurious_bit", bit_valid_l, 1'b0);
                end else begin
                    e = q_l.pop_front();
                    check("lsb_bit", bit_out_l, e);
                end
            end
            if (rst) begin
                check("s_ready_in_reset", s_ready, 1'b0);
                q_m.delete();
                q_l.delete();
            end else if (s_valid && s_ready) begin
                for (int i = 0; i < 4; i++) begin
                    q_m.push_back(s_data[3-i]);
                    q_l.push_back(s_data[i]);
                end
            end
        end
    end

    typedef struct {
        logic [3:0] word;
        logic [3:0] exp_msb;   // emission order: bit 3 first
        logic [3:0] exp_lsb;   // emission order: bit 3 first
    } vec_t;

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (q_m.size() != 0 || q_l.size() != 0 || bit_valid); i++) begin
            tick();
        end
        check({name, "_msb_queue_empty"}, q_m.size(), 0);
        check({name, "_lsb_queue_empty"}, q_l.size(), 0);
        check({name, "_count_zero"}, fifo_count, 0);
    endtask

    initial begin
        vec_t       vecs [4];
        logic [3:0] fill_w [6];
        int         exp_cnt [7];
        int         exp_acc [7];
        int         cnt_log [7];
        int         acc_log [7];
        logic [3:0] hist;
        int         det, vcnt, n, k, j;
        logic       acc;

        vecs[0] = '{word: 4'b1011, exp_msb: 4'b1011, exp_lsb: 4'b1101};
        vecs[1] = '{word: 4'b0001, exp_msb: 4'b0001, exp_lsb: 4'b1000};
        vecs[2] = '{word: 4'b1100, exp_msb: 4'b1100, exp_lsb: 4'b0011};
        vecs[3] = '{word: 4'b0110, exp_msb: 4'b0110, exp_lsb: 4'b0110};
        fill_w  = '{4'b1001, 4'b0011, 4'b1110, 4'b0100, 4'b1010, 4'b0111};
        exp_cnt = '{1, 1, 2, 3, 4, 3, 4};
        exp_acc = '{1, 1, 1, 1, 1, 0, 1};

        // Reset state
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        #1;
        check("s_ready_after_release", s_ready, 1);
        mon_en = 1'b1;

        // Single words: latency and bit order for both orientations
        foreach (vecs[v]) begin
            s_valid = 1'b1; s_data = vecs[v].word;
            tick();
            s_valid = 1'b0;
            check("lat_no_bit_yet", bit_valid, 0);
            check("lat_count_one", fifo_count, 1);
            for (int b = 0; b < 4; b++) begin
                tick();
                check("vec_bit_valid", bit_valid, 1);
                check("vec_busy", busy, 1);
                check("vec_msb_bit", bit_out, vecs[v].exp_msb[3-b]);
                check("vec_lsb_bit", bit_out_l, vecs[v].exp_lsb[3-b]);
                check("vec_count", fifo_count, 0);
            end
            tick();
            check("vec_done_valid", bit_valid, 0);
            check("vec_done_busy", busy, 0);
        end
        drain("single");

        // Back-to-back words: no gap, 1011 spans the boundary
        s_valid = 1'b1; s_data = 4'b0101;
        tick();
        s_data = 4'b1100;
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!bit_valid && n < 10) begin
            tick();
            n++;
        end
        hist = '0; det = 0; vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bit_valid) begin
                vcnt++;
                hist = {hist[2:0], bit_out};
                if (hist == 4'b1011) det++;
            end
            tick();
        end
        check("b2b_contiguous_bits", vcnt, 8);
        check("b2b_pattern_1011", det, 1);
        check("b2b_after_valid", bit_valid, 0);
        drain("b2b");

        // Fill with held s_valid: backpressure at 4, full+pop gives 4,3,4
        k = 0; j = 0;
        s_valid = 1'b1; s_data = fill_w[0];
        while (k < 6 && j < 7) begin
            @(negedge clk);
            acc = s_ready;
            tick();
            acc_log[j] = int'(acc);
            cnt_log[j] = int'(fifo_count);
            j++;
            if (acc) begin
                k++;
                if (k < 6) s_data = fill_w[k];
            end
        end
        s_valid = 1'b0;
        check("fill_all_accepted", k, 6);
        for (int i = 0; i < 7; i++) begin
            check("fill_count_seq", cnt_log[i], exp_cnt[i]);
            check("fill_ready_seq", acc_log[i], exp_acc[i]);
        end
        drain("fill");

        // Reset during the 2nd bit with two words queued
        s_valid = 1'b1; s_data = 4'b1011;
        tick();
        s_data = 4'b0110;
        tick();
        s_data = 4'b0011;
        tick();
        s_valid = 1'b0;
        check("mid_second_bit", bit_out, 0);
        check("mid_count_before_rst", fifo_count, 2);
        rst = 1'b1;
        #1;
        check("mid_s_ready_in_rst", s_ready, 0);
        tick();
        check("mid_rst_valid", bit_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_s_ready", s_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_residual", bit_valid, 0);
        end
        s_valid = 1'b1; s_data = 4'b1111;
        tick();
        s_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("post_rst_word_valid", bit_valid, 1);
            check("post_rst_word_bit", bit_out, 1);
            tick();
        end
        check("post_rst_word_end", bit_valid, 0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end. Accepts LENGTH-bit words on a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Emits each word one bit per clock as a qualified serial stream. This stream is the serial input of the pattern detector DUT (e.g. the 1011 detector).
- Back-to-back words come out with no idle bubble, so patterns that span word boundaries stay detectable.

Parameters:
- LENGTH, 4, bits per word (>=2).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- MSB_FIRST, 1, 1 = bit LENGTH-1 shifted out first; 0 = bit 0 first.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  block can accept a word this cycle.
- s_data  in  LENGTH  upstream word.
- bit_out  out  1  serial data to detector.
- bit_valid  out  1  bit_out qualified this cycle.
- busy  out  1  shifter holds a word (state SHIFT).
- fifo_count  out  $clog2(DEPTH+1)  words buffered, excluding the shifter.

Behaviour:
- Reset: one clock, synchronous and active-high, rst sampled on rising edge of clk. While rst=1 at an edge:
  - FIFO pointers and fifo_count go to 0; the shifter word is discarded; bit counter goes to 0; state goes to IDLE.
  - bit_out=0, bit_valid=0, busy=0, fifo_count=0.
  - s_ready=0 while rst is high; s_ready=1 in the first cycle after reset release.
- Reset mid-word: the partial word is dropped. No further bits are emitted for it and it is not re-emitted.
- Handshake:
  - Write occurs at an edge where s_valid && s_ready.
  - s_ready = !rst && (fifo_count != DEPTH). It is combinational from registered count only, not from the same-cycle pop.
  - When full, a same-cycle pop does NOT enable a push.
  - s_data need not be held after acceptance.
  - s_valid while s_ready=0 has no effect. The word is not lost from the upstream view; upstream holds it.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH.
  - fifo_count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Overflow and underflow are impossible by construction.
- State machine:
  - IDLE: bit_valid=0, bit_out=0.
    - If fifo_count>0 at an edge, pop head into shifter, bit_cnt<=0, go to SHIFT.
    - A word pushed at edge t into an empty FIFO is popped at edge t+1. Its first bit is visible in the cycle after t+1 (latency 2 edges from acceptance to first bit).
  - SHIFT: bit_valid=1; bit_out = shifter bit selected by MSB_FIRST and bit_cnt.
    - Each edge: bit_cnt+1.
    - At the edge where bit_cnt==LENGTH-1:
      - if fifo_count>0, pop next word, bit_cnt<=0, stay SHIFT. There is no gap cycle, so bit_valid stays high continuously.
      - else go to IDLE.
  - busy = (state==SHIFT).
- Throughput: one bit per clock sustained. Upstream sees s_ready drop only when DEPTH words are queued behind the shifter.
- Simultaneous push into an empty FIFO while in the last bit of a word: the pop condition uses registered fifo_count (0), so the block goes to IDLE for one cycle and then loads. This is a one-cycle bubble and is the required behaviour.
- bit_out is a registered output with no combinational path from s_data.

Test Plan:
- Reset then single word 4'b1011, MSB_FIRST=1 -> bit_valid high for exactly 4 cycles starting 2 edges after acceptance; bit_out sequence 1,0,1,1; busy mirrors bit_valid; fifo_count returns to 0.
- Words 4'b0101 then 4'b1100, pushed on consecutive cycles -> 8 contiguous valid bits 0,1,0,1,1,1,0,0 with no gap; downstream detector sees 1011 across the boundary.
- Fill: hold s_valid=1 with 6 words while shifter busy -> s_ready deasserts when fifo_count=4; all 6 words emerge in order with no loss and no duplication; pointer wrap exercised.
- Full with simultaneous pop: fifo_count=4 at the shifter's last bit, s_valid=1 -> no push that cycle; push accepted the next cycle; fifo_count sequence 4,3,4.
- Reset asserted during the 2nd bit of 4'b1011 with 2 words queued -> next edge: bit_valid=0, fifo_count=0, s_ready=0 during reset; no residual bits after release; a new word 4'b1111 serializes cleanly.
- MSB_FIRST=0, word 4'b1011 -> bit_out sequence 1,1,0,1.
